// File: rtl/chase_input_conditioner_pkg.sv
// Shared constants for the chase input conditioner and its per-pin debouncers.
package chase_input_conditioner_pkg;
  localparam int SYNC_STAGES        = 2;
  localparam int DEBOUNCE_WIDTH_DEF = 8;
  localparam int SPEED_W            = 3;
endpackage

// File: rtl/chase_input_conditioner_debounce_bit.sv
// One pin: 2-flop synchroniser, stability counter, accepted level and
// registered edge pulses that line up with the level update.
module debounce_bit
  import chase_input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_WIDTH = DEBOUNCE_WIDTH_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rose,
  output logic fell
);
  logic [SYNC_STAGES-1:0]    sync_q;
  logic [DEBOUNCE_WIDTH-1:0] cnt_q, cnt_d;
  logic                      stable_q, stable_d;
  logic                      rose_q, rose_d, fell_q, fell_d;
  logic                      sync;

  assign sync = sync_q[SYNC_STAGES-1];

  // All-ones is the accept point, so the counter can never wrap.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    rose_d   = 1'b0;
    fell_d   = 1'b0;
    if (sync == stable_q) begin
      cnt_d = '0;
    end else if (&cnt_q) begin
      stable_d = sync;
      cnt_d    = '0;
      rose_d   = sync;
      fell_d   = ~sync;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rose_q   <= 1'b0;
      fell_q   <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], raw};
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rose_q   <= rose_d;
      fell_q   <= fell_d;
    end
  end

  assign level = stable_q;
  assign rose  = rose_q;
  assign fell  = fell_q;
endmodule

// File: rtl/chase_input_conditioner.sv
// Conditions speed/direction/pause pins for the chase stage: five independent
// debouncers, merged speed change pulse and a press-toggled pause flag.
module chase_input_conditioner
  import chase_input_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_WIDTH = DEBOUNCE_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [SPEED_W-1:0] raw_speed,
  input  logic               raw_dir,
  input  logic               raw_pause,
  output logic [SPEED_W-1:0] speed_code,
  output logic               direction,
  output logic               paused,
  output logic               speed_changed,
  output logic               dir_changed
);
  localparam int NUM_PINS = SPEED_W + 2;
  localparam int DIR_IDX  = SPEED_W;
  localparam int PAU_IDX  = SPEED_W + 1;

  logic [NUM_PINS-1:0] raw_all, level, rose, fell;
  logic                tog_q, tog_d;

  assign raw_all = {raw_pause, raw_dir, raw_speed};

  for (genvar g = 0; g < NUM_PINS; g++) begin : g_pin
    debounce_bit #(.DEBOUNCE_WIDTH(DEBOUNCE_WIDTH)) u_db (
      .clk   (clk),
      .reset (reset),
      .raw   (raw_all[g]),
      .level (level[g]),
      .rose  (rose[g]),
      .fell  (fell[g])
    );
  end

  // The press pulse is already registered; XORing it in makes paused flip on
  // the same edge the debounced pause level rises, and tog_q holds it after.
  assign tog_d = tog_q ^ rose[PAU_IDX];

  always_ff @(posedge clk) begin
    if (reset) tog_q <= 1'b0;
    else       tog_q <= tog_d;
  end

  assign speed_code    = level[SPEED_W-1:0];
  assign direction     = level[DIR_IDX];
  assign paused        = tog_d;
  assign speed_changed = |(rose[SPEED_W-1:0] | fell[SPEED_W-1:0]);
  assign dir_changed   = rose[DIR_IDX] | fell[DIR_IDX];
endmodule
